// File: rtl/uart_rx_led.sv
// uart_rx_led: 8N1 UART receiver whose last good byte drives the board LEDs
module uart_rx_led #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pin,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] L_HALF = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] L_FULL = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t          r_state;
  logic [1:0]      r_sync;
  logic [CW-1:0]   r_clk_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shreg;
  logic [7:0]      r_data;
  logic            r_done;
  logic            r_err;
  logic            w_rx;
  assign w_rx      = r_sync[1];
  assign data_out  = r_data;
  assign rx_done   = r_done;
  assign frame_err = r_err;
  assign busy      = r_state != IDLE;
  // two-flop synchroniser; resets to idle-high so reset release is not a start bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], rx_pin};
  // receive FSM: mid-bit sampling, one-cycle done/error pulses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE:
          if (!w_rx) begin
            r_state   <= START;
            r_clk_cnt <= '0;
          end
        START:
          if (r_clk_cnt == L_HALF) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_state   <= w_rx ? IDLE : DATA;
          end else r_clk_cnt <= r_clk_cnt + 1'b1;
        DATA:
          if (r_clk_cnt == L_FULL) begin
            r_clk_cnt <= '0;
            r_shreg   <= {w_rx, r_shreg[7:1]};
            if (r_bit_cnt == 3'd7) r_state <= STOP;
            else r_bit_cnt <= r_bit_cnt + 3'd1;
          end else r_clk_cnt <= r_clk_cnt + 1'b1;
        STOP:
          if (r_clk_cnt == L_FULL) begin
            r_clk_cnt <= '0;
            if (w_rx) begin
              r_data  <= r_shreg;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_err   <= 1'b1;
              r_state <= BREAK;
            end
          end else r_clk_cnt <= r_clk_cnt + 1'b1;
        BREAK:
          if (w_rx) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_led.sv
// tb_uart_rx_led: directed checks of the UART receiver at two baud constants
module tb_uart_rx_led;
  logic clk = 0, rst_n = 0, rx0 = 1, rx1 = 1;
  logic [7:0] data_out0, data_out1;
  logic rx_done0, frame_err0, busy0, rx_done1, frame_err1, busy1;
  int vec = 0, miss = 0, cyc = 0, t0 = 0;
  int dcnt0 = 0, ecnt0 = 0, lcyc0 = 0, pcyc0 = 0, both = 0;
  int dcnt1 = 0, ecnt1 = 0, lcyc1 = 0;
  logic [7:0] ldat0 = 0, pdat0 = 0;

  uart_rx_led #(.CLKS_PER_BIT(16)) u0 (
    .clk(clk), .rst_n(rst_n), .rx_pin(rx0), .data_out(data_out0),
    .rx_done(rx_done0), .frame_err(frame_err0), .busy(busy0));
  uart_rx_led #(.CLKS_PER_BIT(100)) u1 (
    .clk(clk), .rst_n(rst_n), .rx_pin(rx1), .data_out(data_out1),
    .rx_done(rx_done1), .frame_err(frame_err1), .busy(busy1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (rx_done0) begin
      dcnt0++;
      pcyc0 = lcyc0; lcyc0 = cyc;
      pdat0 = ldat0; ldat0 = data_out0;
    end
    if (frame_err0) ecnt0++;
    if (rx_done0 && frame_err0) both++;
    if (rx_done1 && frame_err1) both++;
    if (rx_done1) begin dcnt1++; lcyc1 = cyc; end
    if (frame_err1) ecnt1++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit ch, input logic v, input int per);
    if (ch) rx1 = v; else rx0 = v;
    repeat (per) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit ch, input logic [7:0] b, input logic stop, input int per);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    t0 = cyc;
    for (int i = 0; i < 10; i++) drive(ch, f[i], per);
  endtask

  initial begin
    int n, t;
    bit rose;
    int d, e;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", data_out0, 8'h00);
    chk("rst_done", rx_done0, 1'b0);
    chk("rst_err", frame_err0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    rst_n = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_release_busy", busy0, 1'b0);

    send(0, 8'hA5, 1'b1, 16);
    repeat (5) @(posedge clk);
    #1;
    chk("a5_done_cnt", dcnt0, 1);
    chk("a5_data", data_out0, 8'hA5);
    chk("a5_no_err", ecnt0, 0);
    chk("a5_latency", (lcyc0 - t0 >= 152) && (lcyc0 - t0 <= 156), 1'b1);

    send(0, 8'h3C, 1'b1, 16);
    send(0, 8'hFF, 1'b1, 16);
    repeat (5) @(posedge clk);
    #1;
    chk("b2b_done_cnt", dcnt0, 3);
    chk("b2b_first", pdat0, 8'h3C);
    chk("b2b_second", ldat0, 8'hFF);
    chk("b2b_spacing", (lcyc0 - pcyc0 >= 159) && (lcyc0 - pcyc0 <= 161), 1'b1);

    t = cyc;
    rx0 = 0;
    repeat (3) @(posedge clk);
    #1;
    rx0 = 1;
    rose = 0;
    n = 0;
    while (n < 40 && !(rose && !busy0)) begin
      @(negedge clk);
      if (busy0) rose = 1;
      n++;
    end
    chk("glitch_busy_rose", rose, 1'b1);
    chk("glitch_busy_fall", (cyc - t) <= 11, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    chk("glitch_no_done", dcnt0, 3);
    chk("glitch_no_err", ecnt0, 0);

    send(0, 8'h55, 1'b0, 16);
    drive(0, 1'b0, 40);
    chk("brk_busy_hold", busy0, 1'b1);
    chk("brk_err_once", ecnt0, 1);
    chk("brk_data_kept", data_out0, 8'hFF);
    chk("brk_no_done", dcnt0, 3);
    drive(0, 1'b1, 20);
    chk("brk_idle", busy0, 1'b0);
    send(0, 8'h12, 1'b1, 16);
    repeat (5) @(posedge clk);
    #1;
    chk("after_brk_data", data_out0, 8'h12);
    chk("after_brk_err", ecnt0, 1);
    chk("after_brk_done", dcnt0, 4);

    drive(0, 1'b0, 16);
    for (int i = 0; i < 4; i++) drive(0, 1'b1, 16);
    drive(0, 1'b0, 8);
    rst_n = 0;
    #1;
    chk("midrst_data", data_out0, 8'h00);
    chk("midrst_busy", busy0, 1'b0);
    chk("midrst_done", rx_done0, 1'b0);
    rx0 = 1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1;
    d = dcnt0;
    e = ecnt0;
    repeat (200) @(posedge clk);
    #1;
    chk("midrst_no_pulse", (dcnt0 == d) && (ecnt0 == e), 1'b1);
    send(0, 8'h81, 1'b1, 16);
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_data", data_out0, 8'h81);
    chk("post_rst_done", dcnt0, d + 1);

    send(1, 8'hC3, 1'b1, 100);
    repeat (5) @(posedge clk);
    #1;
    chk("nom_data", data_out1, 8'hC3);
    chk("nom_latency", (lcyc1 - t0 >= 950) && (lcyc1 - t0 <= 954), 1'b1);
    send(1, 8'h96, 1'b1, 96);
    drive(1, 1'b1, 50);
    chk("fast_data", data_out1, 8'h96);
    send(1, 8'h5A, 1'b1, 104);
    drive(1, 1'b1, 50);
    chk("slow_data", data_out1, 8'h5A);
    chk("tol_counts", (dcnt1 == 3) && (ecnt1 == 0), 1'b1);
    chk("done_err_exclusive", both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
